// File: rtl/gb_lcd_capture.sv
// gb_lcd_capture: write side of the double-banked GameBoy LCD framebuffer.
// Turns the PPU's 160x144 2-bit pixel stream into linear framebuffer writes,
// swaps banks only when a whole frame has landed, and paints the bank with
// colour 0 whenever the LCD is switched off.
//
// Handshake note: there is no backpressure. PX_VALID qualifies LD for exactly
// the cycle it is high, and FB_WE qualifies FB_ADDR/FB_DATA for exactly the
// cycle it is high; the RAM must accept every strobe.
module gb_lcd_capture #(
    parameter int H_PIXELS = 160,
    parameter int V_PIXELS = 144,
    parameter int ADDR_W   = 15
) (
    input  logic              GameBoy_clk,
    input  logic              GameBoy_reset_n,
    input  logic [1:0]        LD,
    input  logic              PX_VALID,
    input  logic              FRAME_START,
    input  logic              LCD_EN,
    input  logic              ERR_CLR,
    output logic              FB_WE,
    output logic [ADDR_W-1:0] FB_ADDR,
    output logic [1:0]        FB_DATA,
    output logic              FB_BANK,
    output logic              DISP_BANK,
    output logic              FRAME_DONE,
    output logic              ERR_SHORT
);

    localparam int N = H_PIXELS * V_PIXELS;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);
    localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_CLEAR   = 2'd2,
        S_BLANK   = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        data_q, data_d;
    logic              bank_q, bank_d;
    logic              disp_q, disp_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    // Decode helpers produced by the next-state logic.
    logic              pix_wr;
    logic [ADDR_W-1:0] pix_addr;
    logic              swap;
    logic              short_evt;

    // Next-state, write generation, bank swap and error flag.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        bank_d    = bank_q;
        disp_d    = disp_q;
        done_d    = 1'b0;
        err_d     = err_q;
        pix_wr    = 1'b0;
        pix_addr  = '0;
        swap      = 1'b0;
        short_evt = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!LCD_EN) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end else if (FRAME_START) begin
                    state_d = S_CAPTURE;
                    cnt_d   = '0;
                    // A pixel riding on the start pulse is pixel 0 of the frame.
                    pix_wr  = PX_VALID;
                end
            end
            S_CAPTURE: begin
                if (!LCD_EN) begin
                    // Abandon the partial frame; the display keeps the old bank.
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end else if (FRAME_START) begin
                    // Restart in the same bank; a restart mid-frame is an error.
                    short_evt = (cnt_q != '0);
                    cnt_d     = '0;
                    pix_wr    = PX_VALID;
                end else if (PX_VALID) begin
                    pix_wr   = 1'b1;
                    pix_addr = cnt_q;
                end
            end
            S_CLEAR: begin
                // One colour-0 write per cycle regardless of the PPU inputs.
                we_d   = 1'b1;
                addr_d = cnt_q;
                data_d = 2'd0;
                if (cnt_q == LAST) begin
                    swap    = 1'b1;
                    state_d = S_BLANK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            S_BLANK: begin
                if (LCD_EN) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (pix_wr) begin
            we_d   = 1'b1;
            addr_d = pix_addr;
            data_d = LD;
            if (pix_addr == LAST) begin
                swap    = 1'b1;
                state_d = S_IDLE;
                cnt_d   = '0;
            end else begin
                state_d = S_CAPTURE;
                cnt_d   = pix_addr + ONE;
            end
        end

        if (swap) begin
            disp_d = bank_q;
            bank_d = ~bank_q;
            done_d = 1'b1;
        end

        // A new short-frame event outranks a simultaneous clear.
        if (ERR_CLR) begin
            err_d = 1'b0;
        end
        if (short_evt) begin
            err_d = 1'b1;
        end
    end

    // State and output registers; reset lands on the idle, bank-0 state at once.
    always_ff @(posedge GameBoy_clk or negedge GameBoy_reset_n) begin
        if (!GameBoy_reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= 2'd0;
            bank_q  <= 1'b0;
            disp_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            bank_q  <= bank_d;
            disp_q  <= disp_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign FB_WE      = we_q;
    assign FB_ADDR    = addr_q;
    assign FB_DATA    = data_q;
    assign FB_BANK    = bank_q;
    assign DISP_BANK  = disp_q;
    assign FRAME_DONE = done_q;
    assign ERR_SHORT  = err_q;

endmodule

// File: tb/tb_gb_lcd_capture.sv
// Self-checking bench for gb_lcd_capture: expected writes are queued as the
// pixel stream is driven and matched against FB_WE cycles by a monitor.
`timescale 1ns/1ps
module tb_gb_lcd_capture;

    localparam int H  = 160;
    localparam int V  = 144;
    localparam int AW = 15;
    localparam int N  = H * V;
    localparam int W  = AW + 5; // {done, bank, disp, addr, data}

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    ld;
    logic          px, fs, en, clr;
    logic          fb_we;
    logic [AW-1:0] fb_addr;
    logic [1:0]    fb_data;
    logic          fb_bank, disp_bank, frame_done, err_short;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            done_cnt = 0;
    logic [W-1:0]  exp_q[$];
    logic          m_bank, m_disp;
    logic [W-1:0]  got, want;

    gb_lcd_capture #(.H_PIXELS(H), .V_PIXELS(V), .ADDR_W(AW)) dut (
        .GameBoy_clk     (clk),
        .GameBoy_reset_n (rst_n),
        .LD              (ld),
        .PX_VALID        (px),
        .FRAME_START     (fs),
        .LCD_EN          (en),
        .ERR_CLR         (clr),
        .FB_WE           (fb_we),
        .FB_ADDR         (fb_addr),
        .FB_DATA         (fb_data),
        .FB_BANK         (fb_bank),
        .DISP_BANK       (disp_bank),
        .FRAME_DONE      (frame_done),
        .ERR_SHORT       (err_short)
    );

    // Clock
    always #5 clk = ~clk;

    // Scoreboard monitor: every write must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (fb_we === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_write addr=%0d data=%0d", fb_addr, fb_data);
                end else begin
                    got  = {frame_done, fb_bank, disp_bank, fb_addr, fb_data};
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        n_fail++;
                        $display("FAIL write {done,bank,disp,addr,data} got=%h exp=%h", got, want);
                    end
                end
            end else if (frame_done !== 1'b0) begin
                n_checks++;
                n_fail++;
                $display("FAIL done_without_write frame_done=%b fb_we=%b", frame_done, fb_we);
            end
            if (frame_done === 1'b1) done_cnt++;
        end
    end

    // Watchdog
    initial begin
        #1_500_000;
        n_fail++;
        $display("FAIL watchdog time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Driver: present inputs for one edge, then return 1ns after that edge.
    task automatic drive(input logic p, input logic [1:0] d, input logic f, input logic c);
        px = p; ld = d; fs = f; clr = c;
        @(posedge clk); #1;
        px = 1'b0; fs = 1'b0; clr = 1'b0; ld = 2'($urandom_range(0, 3));
    endtask

    // Model: queue one expected write; the last address of a bank also swaps.
    task automatic exp_write(input int a, input logic [1:0] d);
        if (a == N - 1) begin
            exp_q.push_back({1'b1, ~m_bank, m_bank, AW'(a), d});
            m_disp = m_bank;
            m_bank = ~m_bank;
        end else begin
            exp_q.push_back({1'b0, m_bank, m_disp, AW'(a), d});
        end
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Pixel burst that must not produce writes; returns observed write count.
    task automatic burst(input int n, input logic with_fs, output int seen);
        seen = 0;
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 2'($urandom_range(0, 3)), with_fs & (i == 3), 1'b0);
            if (fb_we === 1'b1) seen++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; px = 1'b0; fs = 1'b0; clr = 1'b0; ld = 2'd0;
        m_bank = 1'b0; m_disp = 1'b1;
        #12;
        n_checks++;
        if ({fb_we, fb_addr, fb_data, fb_bank, disp_bank, frame_done, err_short} !==
            {1'b0, AW'(0), 2'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_in got we=%b addr=%0d data=%0d bank=%b disp=%b done=%b err=%b required 0,0,0,0,1,0,0",
                     fb_we, fb_addr, fb_data, fb_bank, disp_bank, frame_done, err_short);
        end
        #5 rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({fb_we, fb_bank, disp_bank, frame_done, err_short} !== 5'b00100) begin
            n_fail++;
            $display("FAIL reset_out got we=%b bank=%b disp=%b done=%b err=%b required 0,0,1,0,0",
                     fb_we, fb_bank, disp_bank, frame_done, err_short);
        end
    endtask

    task automatic test_back_to_back();
        int base = done_cnt;
        logic [1:0] d;
        drive(1'b0, 2'd0, 1'b1, 1'b0);
        for (int i = 0; i < N; i++) begin
            exp_write(i, i[1:0]);
            drive(1'b1, i[1:0], 1'b0, 1'b0);
        end
        drain();
        n_checks++;
        if ({fb_bank, disp_bank, err_short} !== 3'b100 || done_cnt != base + 1) begin
            n_fail++;
            $display("FAIL frame1 got bank=%b disp=%b err=%b dones=%0d required 1,0,0,1",
                     fb_bank, disp_bank, err_short, done_cnt - base);
        end
        // Second frame: first pixel rides on the start pulse.
        d = 2'($urandom_range(0, 3));
        exp_write(0, d);
        drive(1'b1, d, 1'b1, 1'b0);
        for (int i = 1; i < N; i++) begin
            d = 2'($urandom_range(0, 3));
            exp_write(i, d);
            drive(1'b1, d, 1'b0, 1'b0);
        end
        drain();
        n_checks++;
        if ({fb_bank, disp_bank, err_short} !== 3'b010 || done_cnt != base + 2) begin
            n_fail++;
            $display("FAIL frame2 got bank=%b disp=%b err=%b dones=%0d required 0,1,0,2",
                     fb_bank, disp_bank, err_short, done_cnt - base);
        end
    endtask

    task automatic test_idle_drop();
        int seen;
        burst(12, 1'b0, seen);
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL idle_drop writes=%0d required=0", seen);
        end
    endtask

    task automatic test_short_frame();
        int base;
        logic [1:0] d;
        drive(1'b0, 2'd0, 1'b1, 1'b0);
        for (int i = 0; i < 100; i++) begin
            if ($urandom_range(0, 3) == 0) drive(1'b0, 2'd0, 1'b0, 1'b0);
            d = 2'($urandom_range(0, 3));
            exp_write(i, d);
            drive(1'b1, d, 1'b0, 1'b0);
        end
        base = done_cnt;
        exp_write(0, 2'd3);
        drive(1'b1, 2'd3, 1'b1, 1'b0);
        drain();
        n_checks++;
        if ({err_short, disp_bank, fb_bank} !== 3'b110 || done_cnt != base) begin
            n_fail++;
            $display("FAIL short_frame got err=%b disp=%b bank=%b dones=%0d required 1,1,0,0",
                     err_short, disp_bank, fb_bank, done_cnt - base);
        end
        drive(1'b0, 2'd0, 1'b0, 1'b1);
        n_checks++;
        if (err_short !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clr got=%b required=0", err_short);
        end
        for (int i = 1; i < 10; i++) begin
            exp_write(i, i[1:0]);
            drive(1'b1, i[1:0], 1'b0, 1'b0);
        end
        // Clear and a new short frame together: the set must win.
        drive(1'b0, 2'd0, 1'b1, 1'b1);
        n_checks++;
        if (err_short !== 1'b1) begin
            n_fail++;
            $display("FAIL err_set_wins got=%b required=1", err_short);
        end
        drive(1'b0, 2'd0, 1'b0, 1'b1);
        drain();
        n_checks++;
        if (err_short !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clr2 got=%b required=0", err_short);
        end
    endtask

    task automatic test_clear();
        int base;
        int cycles = 0;
        logic [1:0] d;
        // Frame restarted at cnt 0 above; write 5000 pixels then kill the LCD.
        for (int i = 0; i < 5000; i++) begin
            d = 2'($urandom_range(0, 3));
            exp_write(i, d);
            drive(1'b1, d, 1'b0, 1'b0);
        end
        drain();
        for (int i = 0; i < N; i++) exp_write(i, 2'd0);
        base = done_cnt;
        en = 1'b0;
        while (cycles < N + 10) begin
            @(posedge clk); #1;
            cycles++;
            if (frame_done === 1'b1) break;
            if (cycles < N - 100) begin
                en = 1'($urandom_range(0, 1));
                fs = 1'($urandom_range(0, 1));
                px = 1'($urandom_range(0, 1));
                ld = 2'($urandom_range(0, 3));
            end else begin
                en = 1'b0; fs = 1'b0; px = 1'b0;
            end
        end
        en = 1'b0; fs = 1'b0; px = 1'b0;
        n_checks++;
        if (cycles != N + 1) begin
            n_fail++;
            $display("FAIL clear_length cycles=%0d required=%0d", cycles, N + 1);
        end
        drain();
        n_checks++;
        if ({fb_bank, disp_bank} !== 2'b10 || done_cnt != base + 1) begin
            n_fail++;
            $display("FAIL clear_swap got bank=%b disp=%b dones=%0d required 1,0,1",
                     fb_bank, disp_bank, done_cnt - base);
        end
    endtask

    task automatic test_blank_drop();
        int seen;
        burst(12, 1'b1, seen);
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL blank_drop writes=%0d required=0", seen);
        end
        en = 1'b1;
        drive(1'b0, 2'd0, 1'b0, 1'b0);
        burst(12, 1'b0, seen);
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL blank_to_idle_drop writes=%0d required=0", seen);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] d;
        drive(1'b0, 2'd0, 1'b1, 1'b0);
        for (int i = 0; i < 777; i++) begin
            d = 2'($urandom_range(0, 3));
            exp_write(i, d);
            drive(1'b1, d, 1'b0, 1'b0);
        end
        drain();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({fb_we, fb_addr, fb_data, fb_bank, disp_bank, frame_done, err_short} !==
            {1'b0, AW'(0), 2'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset got we=%b addr=%0d data=%0d bank=%b disp=%b done=%b err=%b required 0,0,0,0,1,0,0",
                     fb_we, fb_addr, fb_data, fb_bank, disp_bank, frame_done, err_short);
        end
        m_bank = 1'b0; m_disp = 1'b1;
        @(negedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        exp_write(0, 2'd2);
        drive(1'b1, 2'd2, 1'b1, 1'b0);
        exp_write(1, 2'd1);
        drive(1'b1, 2'd1, 1'b0, 1'b0);
        drain();
        n_checks++;
        if ({fb_bank, disp_bank, err_short} !== 3'b010) begin
            n_fail++;
            $display("FAIL post_reset got bank=%b disp=%b err=%b required 0,1,0",
                     fb_bank, disp_bank, err_short);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_idle_drop();
        test_short_frame();
        test_clear();
        test_blank_drop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
